// File: rtl/fetch_pc_gen.sv
// Two-wide fetch-address generator with IF/ID packet register.
// Owns the fetch PC, selects the next PC from BTB/hint/ROB inputs and
// registers a two-instruction packet for decode.
module fetch_pc_gen #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clock,
   input  logic        reset,
   output logic [63:0] if_pc,
   output logic [63:0] if_pc_plus_four,
   input  logic [63:0] btb_pred_addr0,
   input  logic [63:0] btb_pred_addr1,
   input  logic        bp_taken0,
   input  logic        bp_taken1,
   input  logic        icache_valid,
   input  logic [31:0] icache_inst0,
   input  logic [31:0] icache_inst1,
   input  logic        id_ready,
   input  logic        rob_mispredict,
   input  logic [63:0] rob_target_pc,
   output logic        if_valid0,
   output logic        if_valid1,
   output logic [31:0] if_inst0,
   output logic [31:0] if_inst1,
   output logic [63:0] if_inst_pc0,
   output logic [63:0] if_inst_pc1,
   output logic [63:0] if_pred_npc0,
   output logic [63:0] if_pred_npc1,
   output logic [1:0]  fetch_state
);

   typedef enum logic [1:0] {
      StRst   = 2'd0,
      StFetch = 2'd1,
      StMiss  = 2'd2,
      StStall = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [63:0] pc_q, pc_d;
   logic        valid0_q, valid0_d;
   logic        valid1_q, valid1_d;
   logic [31:0] inst0_q, inst0_d;
   logic [31:0] inst1_q, inst1_d;
   logic [63:0] inst_pc0_q, inst_pc0_d;
   logic [63:0] inst_pc1_q, inst_pc1_d;
   logic [63:0] npc0_q, npc0_d;
   logic [63:0] npc1_q, npc1_d;

   logic [63:0] pc_plus4, pc_plus8;
   logic [63:0] target0, target1, redirect_pc;
   logic        taken0, taken1;
   logic        active, redirect, adv, pkt_valid;

   // An all-zero BTB entry means "no prediction"; targets are word aligned.
   assign taken0      = bp_taken0 && (btb_pred_addr0 != 64'd0);
   assign taken1      = bp_taken1 && (btb_pred_addr1 != 64'd0);
   assign target0     = {btb_pred_addr0[63:2], 2'b00};
   assign target1     = {btb_pred_addr1[63:2], 2'b00};
   assign redirect_pc = {rob_target_pc[63:2], 2'b00};
   assign pc_plus4    = pc_q + 64'd4;
   assign pc_plus8    = pc_q + 64'd8;

   assign pkt_valid = valid0_q;
   assign active    = (state_q != StRst);
   assign redirect  = active && rob_mispredict;
   assign adv       = active && !rob_mispredict && icache_valid && (!pkt_valid || id_ready);

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StRst;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a redirect always lands in FETCH.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRst:   state_d = StFetch;
         StFetch: begin
            if (!icache_valid) begin
               state_d = StMiss;
            end else if (pkt_valid && !id_ready) begin
               state_d = StStall;
            end
         end
         StMiss:  if (icache_valid) state_d = StFetch;
         StStall: if (id_ready) state_d = StFetch;
         default: state_d = StRst;
      endcase
      if (redirect) begin
         state_d = StFetch;
      end
   end

   // FSM outputs.
   always_comb begin
      fetch_state = state_q;
   end

   // Next PC and next packet contents.
   always_comb begin
      pc_d       = pc_q;
      valid0_d   = valid0_q;
      valid1_d   = valid1_q;
      inst0_d    = inst0_q;
      inst1_d    = inst1_q;
      inst_pc0_d = inst_pc0_q;
      inst_pc1_d = inst_pc1_q;
      npc0_d     = npc0_q;
      npc1_d     = npc1_q;
      if (redirect) begin
         pc_d     = redirect_pc;
         valid0_d = 1'b0;
         valid1_d = 1'b0;
      end else if (adv) begin
         if (taken0) begin
            pc_d = target0;
         end else if (taken1) begin
            pc_d = target1;
         end else begin
            pc_d = pc_plus8;
         end
         valid0_d   = 1'b1;
         valid1_d   = !taken0;
         inst0_d    = icache_inst0;
         inst1_d    = icache_inst1;
         inst_pc0_d = pc_q;
         inst_pc1_d = pc_plus4;
         npc0_d     = taken0 ? target0 : pc_plus4;
         npc1_d     = taken1 ? target1 : pc_plus8;
      end else if (active && id_ready) begin
         // Decode consumed the packet and nothing replaces it.
         valid0_d = 1'b0;
         valid1_d = 1'b0;
      end
   end

   // PC and packet registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         valid0_q   <= 1'b0;
         valid1_q   <= 1'b0;
         inst0_q    <= 32'd0;
         inst1_q    <= 32'd0;
         inst_pc0_q <= 64'd0;
         inst_pc1_q <= 64'd0;
         npc0_q     <= 64'd0;
         npc1_q     <= 64'd0;
      end else begin
         pc_q       <= pc_d;
         valid0_q   <= valid0_d;
         valid1_q   <= valid1_d;
         inst0_q    <= inst0_d;
         inst1_q    <= inst1_d;
         inst_pc0_q <= inst_pc0_d;
         inst_pc1_q <= inst_pc1_d;
         npc0_q     <= npc0_d;
         npc1_q     <= npc1_d;
      end
   end

   assign if_pc           = pc_q;
   assign if_pc_plus_four = pc_plus4;
   assign if_valid0       = valid0_q;
   assign if_valid1       = valid1_q;
   assign if_inst0        = inst0_q;
   assign if_inst1        = inst1_q;
   assign if_inst_pc0     = inst_pc0_q;
   assign if_inst_pc1     = inst_pc1_q;
   assign if_pred_npc0    = npc0_q;
   assign if_pred_npc1    = npc1_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized self-checking bench for fetch_pc_gen against a behavioural model.
module tb_fetch_pc_gen;

   localparam logic [63:0] RstPc = 64'h1000;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] if_pc, if_pc_plus_four;
   logic [63:0] btb_pred_addr0, btb_pred_addr1;
   logic        bp_taken0, bp_taken1;
   logic        icache_valid;
   logic [31:0] icache_inst0, icache_inst1;
   logic        id_ready;
   logic        rob_mispredict;
   logic [63:0] rob_target_pc;
   logic        if_valid0, if_valid1;
   logic [31:0] if_inst0, if_inst1;
   logic [63:0] if_inst_pc0, if_inst_pc1;
   logic [63:0] if_pred_npc0, if_pred_npc1;
   logic [1:0]  fetch_state;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic [63:0] m_pc;
   logic        m_v0, m_v1;
   logic [63:0] m_inst0, m_inst1, m_ipc0, m_ipc1, m_npc0, m_npc1;
   int          m_st; // 0 RST, 1 FETCH, 2 MISS, 3 STALL

   always #5 clock = ~clock;

   fetch_pc_gen #(.RESET_PC(RstPc)) dut (
      .clock           (clock),
      .reset           (reset),
      .if_pc           (if_pc),
      .if_pc_plus_four (if_pc_plus_four),
      .btb_pred_addr0  (btb_pred_addr0),
      .btb_pred_addr1  (btb_pred_addr1),
      .bp_taken0       (bp_taken0),
      .bp_taken1       (bp_taken1),
      .icache_valid    (icache_valid),
      .icache_inst0    (icache_inst0),
      .icache_inst1    (icache_inst1),
      .id_ready        (id_ready),
      .rob_mispredict  (rob_mispredict),
      .rob_target_pc   (rob_target_pc),
      .if_valid0       (if_valid0),
      .if_valid1       (if_valid1),
      .if_inst0        (if_inst0),
      .if_inst1        (if_inst1),
      .if_inst_pc0     (if_inst_pc0),
      .if_inst_pc1     (if_inst_pc1),
      .if_pred_npc0    (if_pred_npc0),
      .if_pred_npc1    (if_pred_npc1),
      .fetch_state     (fetch_state)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of the behavioural model, using the inputs the DUT just sampled.
   task automatic model_step();
      logic        t0, t1, adv;
      logic [63:0] a0, a1;
      int          nst;
      if (!reset) begin
         m_pc = RstPc; m_v0 = 0; m_v1 = 0; m_st = 0;
         m_inst0 = 0; m_inst1 = 0; m_ipc0 = 0; m_ipc1 = 0; m_npc0 = 0; m_npc1 = 0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (rob_mispredict) begin
         m_pc = rob_target_pc & ~64'd3;
         m_v0 = 0; m_v1 = 0; m_st = 1;
      end else begin
         a0 = btb_pred_addr0 & ~64'd3;
         a1 = btb_pred_addr1 & ~64'd3;
         t0 = bp_taken0 && (btb_pred_addr0 != 0);
         t1 = bp_taken1 && (btb_pred_addr1 != 0);
         adv = icache_valid && (!m_v0 || id_ready);
         nst = m_st;
         if (m_st == 1) begin
            if (!icache_valid) nst = 2;
            else if (m_v0 && !id_ready) nst = 3;
         end else if (m_st == 2) begin
            if (icache_valid) nst = 1;
         end else if (id_ready) begin
            nst = 1;
         end
         if (adv) begin
            m_v0 = 1; m_v1 = !t0;
            m_inst0 = {32'd0, icache_inst0}; m_inst1 = {32'd0, icache_inst1};
            m_ipc0 = m_pc; m_ipc1 = m_pc + 4;
            m_npc0 = t0 ? a0 : m_pc + 4;
            m_npc1 = t1 ? a1 : m_pc + 8;
            m_pc = t0 ? a0 : (t1 ? a1 : m_pc + 8);
         end else if (id_ready) begin
            m_v0 = 0; m_v1 = 0;
         end
         m_st = nst;
      end
   endtask

   task automatic compare_all();
      check_val("if_pc", if_pc, m_pc);
      check_val("if_pc_plus_four", if_pc_plus_four, m_pc + 64'd4);
      check_val("fetch_state", {62'd0, fetch_state}, 64'(m_st));
      check_val("if_valid0", {63'd0, if_valid0}, {63'd0, m_v0});
      check_val("if_valid1", {63'd0, if_valid1}, {63'd0, m_v1});
      check_val("if_inst0", {32'd0, if_inst0}, m_inst0);
      check_val("if_inst1", {32'd0, if_inst1}, m_inst1);
      check_val("if_inst_pc0", if_inst_pc0, m_ipc0);
      check_val("if_inst_pc1", if_inst_pc1, m_ipc1);
      check_val("if_pred_npc0", if_pred_npc0, m_npc0);
      check_val("if_pred_npc1", if_pred_npc1, m_npc1);
   endtask

   // Inputs are already set (after a negedge); clock once and compare.
   task automatic tick();
      icache_inst0 = $urandom;
      icache_inst1 = $urandom;
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
   endtask

   task automatic idle_inputs();
      reset = 1; btb_pred_addr0 = 0; btb_pred_addr1 = 0; bp_taken0 = 0; bp_taken1 = 0;
      icache_valid = 1; id_ready = 1; rob_mispredict = 0; rob_target_pc = 0;
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) a = 64'd0;
      else if (sel == 1) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, 16'hffff));
      return a;
   endfunction

   initial begin
      idle_inputs();
      reset = 0;
      @(negedge clock);
      tick();
      tick();
      check_val("reset_pc", if_pc, 64'h1000);
      check_val("reset_valid0", {63'd0, if_valid0}, 64'd0);

      // Straight-line fetch.
      reset = 1;
      tick();                         // RST -> FETCH, no fetch
      check_val("first_state", {62'd0, fetch_state}, 64'd1);
      tick();
      check_val("pkt0_pc", if_inst_pc0, 64'h1000);
      tick();
      check_val("pkt1_pc", if_inst_pc0, 64'h1008);
      check_val("pkt1_npc1", if_pred_npc1, 64'h1010);
      tick();
      check_val("pkt2_pc", if_inst_pc0, 64'h1010);

      // Slot-0 taken with unaligned target squashes slot 1.
      bp_taken0 = 1; btb_pred_addr0 = 64'h2003;
      tick();
      check_val("taken0_pc", if_pc, 64'h2000);
      check_val("taken0_valid1", {63'd0, if_valid1}, 64'd0);
      check_val("taken0_npc0", if_pred_npc0, 64'h2000);
      bp_taken0 = 0; btb_pred_addr0 = 0;

      // Slot-1 hint with zero target counts as not taken.
      bp_taken1 = 1; btb_pred_addr1 = 0;
      tick();
      check_val("zero_tgt_pc", if_pc, 64'h2008);
      bp_taken1 = 0;

      // Stall for three cycles, then release.
      id_ready = 0;
      repeat (3) tick();
      check_val("stall_state", {62'd0, fetch_state}, 64'd3);
      id_ready = 1;
      tick();
      tick();

      // Miss with mid-miss redirect.
      icache_valid = 0;
      tick();
      rob_mispredict = 1; rob_target_pc = 64'h3000;
      tick();
      rob_mispredict = 0;
      check_val("redir_pc", if_pc, 64'h3000);
      check_val("redir_state", {62'd0, fetch_state}, 64'd1);
      tick();
      tick();
      check_val("miss_no_stale", {63'd0, if_valid0}, 64'd0);
      icache_valid = 1;
      tick();
      check_val("redir_pkt_pc", if_inst_pc0, 64'h3000);

      // PC wrap.
      rob_mispredict = 1; rob_target_pc = 64'hFFFF_FFFF_FFFF_FFFB;
      tick();
      rob_mispredict = 0;
      tick();
      check_val("wrap_pc", if_pc, 64'd0);
      check_val("wrap_npc1", if_pred_npc1, 64'd0);

      // Reset in the middle of a stall, with a coincident mispredict.
      id_ready = 0;
      tick();
      reset = 0; rob_mispredict = 1; rob_target_pc = 64'h5000;
      tick();
      check_val("rst_stall_valid0", {63'd0, if_valid0}, 64'd0);
      check_val("rst_stall_pc", if_pc, RstPc);
      idle_inputs();
      tick();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 99) >= 2);
         bp_taken0      = ($urandom_range(0, 3) == 0);
         bp_taken1      = ($urandom_range(0, 3) == 0);
         btb_pred_addr0 = rand_addr();
         btb_pred_addr1 = rand_addr();
         icache_valid   = ($urandom_range(0, 9) < 8);
         id_ready       = ($urandom_range(0, 9) < 7);
         rob_mispredict = ($urandom_range(0, 19) == 0);
         rob_target_pc  = rand_addr();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
